// File: rtl/microprogram_sequencer.sv
// Purpose : microprogrammed control unit with a writable DEPTH x CW_W control store,
//           a control address register (CAR) and next-address logic.
// Latency : control_word is registered together with car (new word visible right after the edge).
// Backpr. : i_stall freezes car/control_word/ind_done; writes are accepted only while halted.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_map_addr, i_ind         opcode-decoder entry address and indirect-operand flag
//   i_cond                    branch condition used by TEST words
//   i_stall, i_start          hold the sequencer / leave the halted state
//   i_wr_en/addr/data         control-store write port (halted only); o_wr_ack pulses a cycle later
//   o_car, o_control_word     current microinstruction address and registered word
//   o_halted                  sequencer is halted
module microprogram_sequencer #(
  parameter int                ADDR_W       = 7,
  parameter int                CW_W         = 24,
  parameter logic [ADDR_W-1:0] IND_ADDR     = 7'h05,
  parameter bit                START_HALTED = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_map_addr,
  input  logic              i_ind,
  input  logic              i_cond,
  input  logic              i_stall,
  input  logic              i_start,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [CW_W-1:0]   i_wr_data,
  output logic              o_wr_ack,
  output logic [ADDR_W-1:0] o_car,
  output logic [CW_W-1:0]   o_control_word,
  output logic              o_halted
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int HALT_B = CW_W - 1;
  localparam int SEQ_HI = CW_W - 3;
  localparam int SEQ_LO = CW_W - 4;

  localparam logic [1:0] SEQ_TEST = 2'b00;
  localparam logic [1:0] SEQ_DISP = 2'b01;
  localparam logic [1:0] SEQ_INC  = 2'b10;
  localparam logic [1:0] SEQ_END  = 2'b11;

  // Control store: deliberately not reset, contents survive rst_n.
  logic [CW_W-1:0]   r_mem [DEPTH];

  logic [ADDR_W-1:0] r_car;
  logic [CW_W-1:0]   r_cw;
  logic              r_halted;
  logic              r_ind_done;
  logic              r_wr_ack;

  logic [ADDR_W-1:0] w_nxt;
  logic [ADDR_W-1:0] w_car_inc;
  logic              w_ind_set;
  logic              w_wr_fire;
  logic [CW_W-1:0]   w_start_word;

  assign w_car_inc = r_car + ADDR_W'(1);   // natural wrap at DEPTH-1
  assign w_wr_fire = r_halted & i_wr_en;

  // A write to address 0 in the same cycle as start is forwarded so the
  // first word after restart already reflects it.
  assign w_start_word = (w_wr_fire && (i_wr_addr == '0)) ? i_wr_data : r_mem[0];

  // Next-address selection from the SEQ field of the word currently issued.
  always_comb begin
    w_nxt     = '0;
    w_ind_set = 1'b0;
    case (r_cw[SEQ_HI:SEQ_LO])
      SEQ_INC: w_nxt = w_car_inc;
      SEQ_END: w_nxt = '0;
      SEQ_DISP: begin
        // First DISPATCH of an indirect instruction detours through the
        // indirect routine; the routine's own closing DISPATCH goes to map_addr.
        if (i_ind && !r_ind_done) begin
          w_nxt     = IND_ADDR;
          w_ind_set = 1'b1;
        end else begin
          w_nxt = i_map_addr;
        end
      end
      default: w_nxt = i_cond ? w_car_inc : '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_wr_fire) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_car      <= '0;
      r_ind_done <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_halted   <= START_HALTED;
      r_cw       <= START_HALTED ? '0 : r_mem[0];
    end else begin
      r_wr_ack <= w_wr_fire;
      if (r_halted) begin
        if (i_start) begin
          r_halted   <= 1'b0;
          r_car      <= '0;
          r_ind_done <= 1'b0;
          r_cw       <= w_start_word;
        end
      end else if (!i_stall) begin
        r_car      <= w_nxt;
        // Returning to address 0 marks the start of a new instruction.
        r_ind_done <= (w_nxt == '0) ? 1'b0 : (r_ind_done | w_ind_set);
        if (r_cw[HALT_B]) begin
          r_halted <= 1'b1;
          r_cw     <= '0;
        end else begin
          r_cw <= r_mem[w_nxt];
        end
      end
    end
  end

  assign o_car          = r_car;
  assign o_control_word = r_cw;
  assign o_halted       = r_halted;
  assign o_wr_ack       = r_wr_ack;

endmodule

// File: tb/tb_microprogram_sequencer.sv
module tb_microprogram_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  map_addr;
  logic        ind, cond, stall, start, wr_en;
  logic [6:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_ack, halted;
  logic [6:0]  car;
  logic [23:0] cw;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  microprogram_sequencer #(
    .ADDR_W(7), .CW_W(24), .IND_ADDR(7'h05), .START_HALTED(1'b1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_map_addr(map_addr), .i_ind(ind),
    .i_cond(cond), .i_stall(stall), .i_start(start), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .o_car(car), .o_control_word(cw), .o_halted(halted)
  );

  // ---------------- behavioural reference model ----------------
  logic [23:0] mm [128];
  int m_car;
  bit m_halted, m_ind, m_ack;

  function automatic logic [23:0] m_cw();
    return m_halted ? 24'h0 : mm[m_car];
  endfunction

  task automatic model_step();
    logic [23:0] w;
    int nxt;
    if (!rst_n) begin
      m_car = 0; m_ind = 0; m_ack = 0; m_halted = 1;
      return;
    end
    m_ack = m_halted && wr_en;
    if (m_halted) begin
      if (wr_en) mm[wr_addr] = wr_data;
      if (start) begin m_halted = 0; m_car = 0; m_ind = 0; end
    end else if (!stall) begin
      w = mm[m_car];
      case (w[21:20])
        2'b10: nxt = (m_car + 1) % 128;
        2'b11: nxt = 0;
        2'b01: if (ind && !m_ind) begin nxt = 5; m_ind = 1; end
               else nxt = int'(map_addr);
        default: nxt = cond ? (m_car + 1) % 128 : 0;
      endcase
      if (nxt == 0) m_ind = 0;
      m_car = nxt;
      if (w[23]) m_halted = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1; map_addr = 0; ind = 0; cond = 0; stall = 0; start = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [23:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; tick(); rst_n = 1;
  endtask

  function automatic logic [23:0] rw(input logic [3:0] top);
    logic [19:0] lo;
    lo = 20'($urandom);
    return {top, lo};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    rst_n = 0; start = 1; stall = 1;
    tick();
    n_chk++; if (car !== 7'h00) $display("FAIL reset_car got=%h exp=00", car); else n_pass++;
    n_chk++; if (cw !== 24'h0) $display("FAIL reset_cw got=%h exp=000000", cw); else n_pass++;
    n_chk++; if (halted !== 1'b1) $display("FAIL reset_halted got=%b exp=1", halted); else n_pass++;
    n_chk++; if (wr_ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", wr_ack); else n_pass++;
    idle();
  endtask

  task automatic test_load_restart();
    logic [23:0] exp_cw;
    for (int i = 0; i < 128; i++) begin
      wr_en = 1; wr_addr = 7'(i); wr_data = rw(4'hB);
      tick();
      n_chk++; if (wr_ack !== 1'b1) $display("FAIL fill_ack addr=%0d got=%b exp=1", i, wr_ack); else n_pass++;
    end
    wr(7'h00, 24'h200004);
    n_chk++; if (wr_ack !== 1'b1) $display("FAIL ack0 got=%b exp=1", wr_ack); else n_pass++;
    wr(7'h01, 24'h300000);
    n_chk++; if (wr_ack !== 1'b1) $display("FAIL ack1 got=%b exp=1", wr_ack); else n_pass++;
    tick();
    n_chk++; if (wr_ack !== 1'b0) $display("FAIL ack_pulse got=%b exp=0", wr_ack); else n_pass++;
    start = 1; tick(); start = 0;
    n_chk++; if (car !== 7'h00 || cw !== 24'h200004 || halted !== 1'b0)
      $display("FAIL restart got car=%h cw=%h h=%b exp car=00 cw=200004 h=0", car, cw, halted); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_cw = (k % 2 == 0) ? 24'h300000 : 24'h200004;
      n_chk++; if (car !== 7'((k + 1) % 2) || cw !== exp_cw)
        $display("FAIL loop%0d got car=%h cw=%h exp car=%h cw=%h", k, car, cw, (k + 1) % 2, exp_cw); else n_pass++;
    end
    do_reset();
  endtask

  task automatic test_indirect();
    int q[$];
    for (int i = 0; i < 4; i++) wr(7'(i), rw(4'h2));
    wr(7'h04, rw(4'h1));
    wr(7'h05, rw(4'h2));
    wr(7'h06, rw(4'h1));
    wr(7'h0B, rw(4'hB));
    for (int pass = 0; pass < 2; pass++) begin
      ind = (pass == 0); map_addr = 7'h0B;
      if (pass == 0) q = '{0, 1, 2, 3, 4, 5, 6, 11};
      else           q = '{0, 1, 2, 3, 4, 11};
      start = 1; tick(); start = 0;
      for (int k = 0; k < q.size(); k++) begin
        if (k > 0) tick();
        n_chk++; if (car !== 7'(q[k]) || halted !== 1'b0)
          $display("FAIL ind%0d_step%0d got car=%h h=%b exp car=%h h=0", pass, k, car, halted, q[k]); else n_pass++;
      end
      tick();
      n_chk++; if (halted !== 1'b1 || car !== 7'h00 || cw !== 24'h0)
        $display("FAIL ind%0d_halt got h=%b car=%h cw=%h exp h=1 car=00 cw=0", pass, halted, car, cw); else n_pass++;
    end
    idle();
  endtask

  task automatic test_cond();
    int q[$];
    wr(7'h00, rw(4'h1));
    wr(7'h11, rw(4'h0));
    wr(7'h12, rw(4'hB));
    ind = 1; map_addr = 7'h11;
    q = '{0, 5, 6, 17, 0, 5, 6, 17, 18};
    start = 1; tick(); start = 0;
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) begin cond = (k == 8); tick(); end
      n_chk++; if (car !== 7'(q[k]))
        $display("FAIL cond_step%0d got car=%h exp car=%h", k, car, q[k]); else n_pass++;
    end
    tick();
    n_chk++; if (halted !== 1'b1 || car !== 7'h00)
      $display("FAIL cond_halt got h=%b car=%h exp h=1 car=00", halted, car); else n_pass++;
    idle();
  endtask

  task automatic test_stall();
    logic [23:0] w0c, w0d;
    w0c = rw(4'h2); w0d = rw(4'hB);
    wr(7'h00, rw(4'h1));
    wr(7'h0C, w0c);
    wr(7'h0D, w0d);
    map_addr = 7'h0C;
    start = 1; tick(); start = 0;
    tick();
    n_chk++; if (car !== 7'h0C || cw !== w0c) $display("FAIL stall_entry got car=%h cw=%h exp car=0c cw=%h", car, cw, w0c); else n_pass++;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      cond = 1'($urandom); tick();
      n_chk++; if (car !== 7'h0C || cw !== w0c) $display("FAIL stall_hold%0d got car=%h cw=%h exp car=0c cw=%h", k, car, cw, w0c); else n_pass++;
    end
    stall = 0; tick();
    n_chk++; if (car !== 7'h0D || cw !== w0d) $display("FAIL stall_adv got car=%h cw=%h exp car=0d cw=%h", car, cw, w0d); else n_pass++;
    stall = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++; if (halted !== 1'b0 || car !== 7'h0D) $display("FAIL stall_halt%0d got h=%b car=%h exp h=0 car=0d", k, halted, car); else n_pass++;
    end
    stall = 0; tick();
    n_chk++; if (halted !== 1'b1 || car !== 7'h00 || cw !== 24'h0)
      $display("FAIL stall_halted got h=%b car=%h cw=%h exp h=1 car=00 cw=0", halted, car, cw); else n_pass++;
    idle();
  endtask

  task automatic test_halt_write();
    logic [23:0] w0, w1;
    w0 = rw(4'h3); w1 = rw(4'h3);
    wr(7'h00, w0);
    start = 1; tick(); start = 0;
    wr_en = 1; wr_addr = 7'h00; wr_data = ~w0; tick(); wr_en = 0;
    n_chk++; if (wr_ack !== 1'b0) $display("FAIL run_wr_ack got=%b exp=0", wr_ack); else n_pass++;
    tick();
    n_chk++; if (cw !== w0) $display("FAIL run_wr_ignored got cw=%h exp=%h", cw, w0); else n_pass++;
    do_reset();
    start = 1; tick(); start = 0;
    n_chk++; if (cw !== w0 || car !== 7'h00 || halted !== 1'b0)
      $display("FAIL resume got cw=%h car=%h h=%b exp cw=%h car=00 h=0", cw, car, halted, w0); else n_pass++;
    do_reset();
    wr_en = 1; wr_addr = 7'h00; wr_data = w1; start = 1; tick(); wr_en = 0; start = 0;
    n_chk++; if (cw !== w1 || halted !== 1'b0 || wr_ack !== 1'b1)
      $display("FAIL write_first got cw=%h h=%b ack=%b exp cw=%h h=0 ack=1", cw, halted, wr_ack, w1); else n_pass++;
    do_reset();
    idle();
  endtask

  task automatic test_reset_mid();
    logic [23:0] w00, w22;
    w00 = rw(4'h1); w22 = rw(4'h2);
    wr(7'h00, w00);
    wr(7'h22, w22);
    wr(7'h23, rw(4'hB));
    map_addr = 7'h22;
    start = 1; tick(); start = 0;
    tick();
    n_chk++; if (car !== 7'h22) $display("FAIL mid_reach got car=%h exp=22", car); else n_pass++;
    stall = 1; rst_n = 0; tick(); rst_n = 1; stall = 0;
    n_chk++; if (car !== 7'h00 || halted !== 1'b1 || wr_ack !== 1'b0 || cw !== 24'h0)
      $display("FAIL mid_reset got car=%h h=%b ack=%b cw=%h exp car=00 h=1 ack=0 cw=0", car, halted, wr_ack, cw); else n_pass++;
    start = 1; tick(); start = 0;
    n_chk++; if (cw !== w00) $display("FAIL mid_keep0 got cw=%h exp=%h", cw, w00); else n_pass++;
    tick();
    n_chk++; if (car !== 7'h22 || cw !== w22) $display("FAIL mid_keep22 got car=%h cw=%h exp car=22 cw=%h", car, cw, w22); else n_pass++;
    do_reset();
    idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      start    = ($urandom_range(0, 3) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      cond     = 1'($urandom);
      ind      = 1'($urandom);
      map_addr = 7'($urandom);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 7'($urandom);
      wr_data  = {($urandom_range(0, 5) == 0), 23'($urandom)};
      tick();
      n_chk++;
      if ({car, cw, halted, wr_ack} !== {7'(m_car), m_cw(), m_halted, m_ack})
        $display("FAIL rand%0d got car=%h cw=%h h=%b ack=%b exp car=%h cw=%h h=%b ack=%b",
                 k, car, cw, halted, wr_ack, 7'(m_car), m_cw(), m_halted, m_ack);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_restart();
    test_indirect();
    test_cond();
    test_stall();
    test_halt_write();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
